// File: rtl/data_ram_responder.sv
// data_ram_responder: word-organised data RAM behind the core's ahb_* load/store
// port. One access at a time, WAIT_CYCLES wait states shown on ahb_busy, byte,
// halfword and word lanes, read data returned with a one-cycle ahb_rd_vld strobe.
// Ports: clk, rst_n (async, active low); ahb_rd_en/ahb_wr_en requests;
// ahb_addr byte address; ahb_wr_data right-justified; ahb_size 00 b/01 h/1x w;
// ahb_rd_data zero-extended read data; ahb_rd_vld, ahb_busy, ahb_err strobes.
// Optional macro MISALIGN_FAULT_EN: misaligned accesses fault via ahb_err.
module data_ram_responder #(
  parameter int ADDR_WIDTH  = 12,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ahb_rd_en,
  input  logic        ahb_wr_en,
  input  logic [31:0] ahb_addr,
  input  logic [31:0] ahb_wr_data,
  input  logic [1:0]  ahb_size,
  output logic [31:0] ahb_rd_data,
  output logic        ahb_rd_vld,
  output logic        ahb_busy,
  output logic        ahb_err
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int AW    = ADDR_WIDTH + 2;
  localparam logic [3:0] CNT_INIT =
    (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  state_t state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic go_done;
  logic req;

  logic [AW-1:0] lat_addr;
  logic [1:0]    lat_size;
  logic [31:0]   lat_data;
  logic          lat_wr;
  logic          lat_rd;

  logic [AW-1:0]         op_addr;
  logic [1:0]            op_size;
  logic [31:0]           op_data;
  logic                  op_wr;
  logic                  op_rd;
  logic                  live;
  logic [1:0]            lane;
  logic [ADDR_WIDTH-1:0] idx;
  logic                  is_byte;
  logic                  is_half;
  logic                  fault;

  logic [3:0]  be;
  logic [31:0] wdat;
  logic [31:0] ram_word;
  logic [31:0] rd_lane;

  logic [31:0] mem [DEPTH];

  logic unused_addr;
  assign unused_addr = ^ahb_addr[31:AW];

  assign req = ahb_rd_en | ahb_wr_en;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    go_done   = 1'b0;
    unique case (state)
      IDLE: begin
        if (req) begin
          if (WAIT_CYCLES > 0) begin
            state_nxt = WAIT;
            cnt_nxt   = CNT_INIT;
          end else begin
            state_nxt = DONE;
            go_done   = 1'b1;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          state_nxt = DONE;
          go_done   = 1'b1;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The access is carried out on the edge that enters DONE. With no wait
  // states that edge is the accept edge, so the live request is used.
  assign live    = (state == IDLE);
  assign op_addr = live ? ahb_addr[AW-1:0] : lat_addr;
  assign op_size = live ? ahb_size : lat_size;
  assign op_data = live ? ahb_wr_data : lat_data;
  assign op_wr   = live ? ahb_wr_en : lat_wr;
  assign op_rd   = live ? (ahb_rd_en & ~ahb_wr_en) : lat_rd;

  assign lane    = op_addr[1:0];
  assign idx     = op_addr[AW-1:2];
  assign is_byte = (op_size == 2'b00);
  assign is_half = (op_size == 2'b01);

`ifdef MISALIGN_FAULT_EN
  logic misaligned;
  assign misaligned = (is_half & lane[0]) |
                      (~is_byte & ~is_half & (lane != 2'b00));
  assign fault = misaligned;
`else
  assign fault = 1'b0;
`endif

  always_comb begin
    be   = 4'b1111;
    wdat = op_data;
    unique case (1'b1)
      is_byte: begin
        be   = 4'b0001 << lane;
        wdat = {4{op_data[7:0]}};
      end
      is_half: begin
        be   = lane[1] ? 4'b1100 : 4'b0011;
        wdat = {2{op_data[15:0]}};
      end
      default: be = 4'b1111;
    endcase
    if (fault) be = 4'b0000;
  end

  assign ram_word = mem[idx];

  always_comb begin
    rd_lane = ram_word;
    unique case (1'b1)
      is_byte: rd_lane = {24'b0, ram_word[{lane, 3'b000} +: 8]};
      is_half: rd_lane = {16'b0, lane[1] ? ram_word[31:16]
                                         : ram_word[15:0]};
      default: rd_lane = ram_word;
    endcase
    if (fault) rd_lane = 32'b0;
  end

  // RAM contents survive reset; a write is only dropped while reset is low.
  always_ff @(posedge clk) begin
    if (rst_n && go_done && op_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdat[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      ahb_busy    <= 1'b0;
      ahb_rd_vld  <= 1'b0;
      ahb_rd_data <= 32'b0;
      lat_addr    <= '0;
      lat_size    <= 2'b00;
      lat_data    <= 32'b0;
      lat_wr      <= 1'b0;
      lat_rd      <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      ahb_busy   <= (state_nxt == WAIT);
      ahb_rd_vld <= go_done & op_rd;
      if (go_done && op_rd) ahb_rd_data <= rd_lane;
      if (live && req) begin
        lat_addr <= ahb_addr[AW-1:0];
        lat_size <= ahb_size;
        lat_data <= ahb_wr_data;
        lat_wr   <= ahb_wr_en;
        lat_rd   <= ahb_rd_en & ~ahb_wr_en;
      end
    end
  end

`ifdef MISALIGN_FAULT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ahb_err <= 1'b0;
    else        ahb_err <= go_done & fault;
  end
`else
  assign ahb_err = 1'b0;
`endif

endmodule

// File: tb/tb_data_ram_responder.sv
// tb_data_ram_responder: vector table, timing sequences and a random
// run against a byte-level memory model for three wait-state settings.
module tb_data_ram_responder;

  localparam int AW = 8;
  localparam int NB = 4 << AW;

  logic clk = 1'b0;
  logic rst_n;

  logic        rd_en   [3];
  logic        wr_en   [3];
  logic [31:0] addr    [3];
  logic [31:0] wdata   [3];
  logic [1:0]  size    [3];
  logic [31:0] rd_data [3];
  logic        rd_vld  [3];
  logic        busy    [3];
  logic        err     [3];

  int checks = 0;
  int errors = 0;

  logic [7:0] mb [int];

  always #5 clk = ~clk;

  data_ram_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(1)) u_w1 (
    .clk(clk), .rst_n(rst_n),
    .ahb_rd_en(rd_en[0]), .ahb_wr_en(wr_en[0]),
    .ahb_addr(addr[0]), .ahb_wr_data(wdata[0]), .ahb_size(size[0]),
    .ahb_rd_data(rd_data[0]), .ahb_rd_vld(rd_vld[0]),
    .ahb_busy(busy[0]), .ahb_err(err[0])
  );

  data_ram_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rst_n(rst_n),
    .ahb_rd_en(rd_en[1]), .ahb_wr_en(wr_en[1]),
    .ahb_addr(addr[1]), .ahb_wr_data(wdata[1]), .ahb_size(size[1]),
    .ahb_rd_data(rd_data[1]), .ahb_rd_vld(rd_vld[1]),
    .ahb_busy(busy[1]), .ahb_err(err[1])
  );

  data_ram_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(15)) u_w15 (
    .clk(clk), .rst_n(rst_n),
    .ahb_rd_en(rd_en[2]), .ahb_wr_en(wr_en[2]),
    .ahb_addr(addr[2]), .ahb_wr_data(wdata[2]), .ahb_size(size[2]),
    .ahb_rd_data(rd_data[2]), .ahb_rd_vld(rd_vld[2]),
    .ahb_busy(busy[2]), .ahb_err(err[2])
  );

  typedef struct {
    int          k;
    bit          r;
    bit          w;
    logic [31:0] a;
    logic [1:0]  s;
    logic [31:0] d;
    bit          ev;
    logic [31:0] eq;
    bit          ee;
  } vec_t;

  vec_t tbl[$];

  function automatic int wc(input int k);
    return (k == 0) ? 1 : (k == 1) ? 0 : 15;
  endfunction

  task automatic check(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  task automatic drive(input int k, input bit r, input bit w,
                       input logic [31:0] a, input logic [1:0] s,
                       input logic [31:0] d);
    rd_en[k] = r;
    wr_en[k] = w;
    addr[k]  = a;
    size[k]  = s;
    wdata[k] = d;
  endtask

  // Called at a negedge; returns at the negedge of the idle cycle that
  // follows completion, so calls chain at the peak access rate.
  task automatic access(input int k, input bit r, input bit w,
                        input logic [31:0] a, input logic [1:0] s,
                        input logic [31:0] d, input bit noise,
                        output logic v, output logic [31:0] q,
                        output logic e, output bit seq_ok);
    int n;
    n = wc(k);
    v = 1'b0;
    q = 32'b0;
    e = 1'b0;
    seq_ok = 1'b1;
    drive(k, r, w, a, s, d);
    for (int c = 1; c <= n + 2; c++) begin
      @(negedge clk);
      if (busy[k] !== (c <= n)) seq_ok = 1'b0;
      if (c == n + 1) begin
        v = rd_vld[k];
        q = rd_data[k];
        e = err[k];
      end else if (rd_vld[k] !== 1'b0 || err[k] !== 1'b0) begin
        seq_ok = 1'b0;
      end
      if (noise && c <= n + 1)
        drive(k, 1'($urandom), 1'($urandom),
              32'h300 + 32'($urandom_range(0, 15)),
              2'($urandom), $urandom);
      else
        drive(k, 1'b0, 1'b0, 32'b0, 2'b00, 32'b0);
    end
  endtask

  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
  endfunction

  function automatic bit mis(input logic [31:0] a, input logic [1:0] s);
`ifdef MISALIGN_FAULT_EN
    return (int'(a[1:0]) % nbytes(s)) != 0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int mbase(input int k, input logic [31:0] a,
                               input logic [1:0] s);
    int off;
    off = int'(a[AW+1:0]);
    return k * NB + off - (off % nbytes(s));
  endfunction

  task automatic m_write(input int k, input logic [31:0] a,
                         input logic [1:0] s, input logic [31:0] d);
    int b;
    if (mis(a, s)) return;
    b = mbase(k, a, s);
    for (int i = 0; i < nbytes(s); i++) mb[b + i] = d[8*i +: 8];
  endtask

  function automatic logic [31:0] m_read(input int k, input logic [31:0] a,
                                         input logic [1:0] s);
    logic [31:0] r;
    int b;
    r = 32'b0;
    if (mis(a, s)) return r;
    b = mbase(k, a, s);
    for (int i = 0; i < nbytes(s); i++)
      r[8*i +: 8] = mb.exists(b + i) ? mb[b + i] : 8'h00;
    return r;
  endfunction

  task automatic held(input int k, input logic [31:0] a,
                      input logic [31:0] exp);
    int n, p, nc;
    logic [63:0] vp, bp, evp, ebp;
    bit dok;
    n = wc(k);
    p = n + 2;
    nc = 3 * p;
    vp = '0; bp = '0; evp = '0; ebp = '0;
    dok = 1'b1;
    drive(k, 1'b1, 1'b0, a, 2'b10, 32'b0);
    for (int c = 1; c <= nc; c++) begin
      @(negedge clk);
      vp[c]  = rd_vld[k];
      bp[c]  = busy[k];
      evp[c] = ((c % p) == n + 1);
      ebp[c] = ((c % p) >= 1) && ((c % p) <= n);
      if (rd_vld[k] === 1'b1 && rd_data[k] !== exp) dok = 1'b0;
    end
    drive(k, 1'b0, 1'b0, 32'b0, 2'b00, 32'b0);
    check($sformatf("held%0d_vld", k), vp, evp);
    check($sformatf("held%0d_busy", k), bp, ebp);
    check($sformatf("held%0d_data", k), 64'(dok), 64'(1));
  endtask

  initial begin
    logic v, e;
    logic [31:0] q;
    bit ok;
    logic [31:0] a, d;
    logic [1:0] s;
    bit r, w;

    for (int k = 0; k < 3; k++) drive(k, 1'b0, 1'b0, 32'b0, 2'b00, 32'b0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++)
      check($sformatf("reset%0d", k),
            {29'b0, rd_data[k], rd_vld[k], busy[k], err[k]}, 64'b0);
    rst_n = 1'b1;
    @(negedge clk);

    tbl.push_back('{0, 0, 1, 32'h10, 2'b10, 32'hDEADBEEF, 0, 32'h0, 0});
    tbl.push_back('{0, 1, 0, 32'h10, 2'b10, 32'h0, 1, 32'hDEADBEEF, 0});
    tbl.push_back('{0, 0, 1, 32'h10, 2'b10, 32'h11223344, 0, 32'h0, 0});
    tbl.push_back('{0, 0, 1, 32'h13, 2'b00, 32'h000000A5, 0, 32'h0, 0});
    tbl.push_back('{0, 1, 0, 32'h10, 2'b10, 32'h0, 1, 32'hA5223344, 0});
    tbl.push_back('{0, 1, 0, 32'h13, 2'b00, 32'h0, 1, 32'h000000A5, 0});
    tbl.push_back('{0, 0, 1, 32'h20, 2'b10, 32'h01020304, 0, 32'h0, 0});
    tbl.push_back('{0, 0, 1, 32'h22, 2'b01, 32'h0000CAFE, 0, 32'h0, 0});
    tbl.push_back('{0, 1, 0, 32'h22, 2'b01, 32'h0, 1, 32'h0000CAFE, 0});
    tbl.push_back('{0, 1, 0, 32'h20, 2'b01, 32'h0, 1, 32'h00000304, 0});
    tbl.push_back('{0, 1, 0, 32'h21, 2'b00, 32'h0, 1, 32'h00000003, 0});
    tbl.push_back('{0, 1, 1, 32'h30, 2'b10, 32'h00000005, 0, 32'h0, 0});
    tbl.push_back('{0, 1, 0, 32'h30, 2'b10, 32'h0, 1, 32'h00000005, 0});
    tbl.push_back('{0, 0, 1, 32'h40, 2'b10, 32'h0BADF00D, 0, 32'h0, 0});
`ifdef MISALIGN_FAULT_EN
    tbl.push_back('{0, 0, 1, 32'h41, 2'b10, 32'h12345678, 0, 32'h0, 1});
    tbl.push_back('{0, 1, 0, 32'h40, 2'b10, 32'h0, 1, 32'h0BADF00D, 0});
    tbl.push_back('{0, 1, 0, 32'h41, 2'b01, 32'h0, 1, 32'h00000000, 1});
    tbl.push_back('{0, 1, 0, 32'h42, 2'b00, 32'h0, 1, 32'h000000AD, 0});
`else
    tbl.push_back('{0, 0, 1, 32'h41, 2'b10, 32'h12345678, 0, 32'h0, 0});
    tbl.push_back('{0, 1, 0, 32'h40, 2'b10, 32'h0, 1, 32'h12345678, 0});
    tbl.push_back('{0, 1, 0, 32'h41, 2'b01, 32'h0, 1, 32'h00005678, 0});
    tbl.push_back('{0, 1, 0, 32'h42, 2'b00, 32'h0, 1, 32'h00000034, 0});
`endif
    tbl.push_back('{0, 0, 1, 32'h50, 2'b11, 32'hFEEDFACE, 0, 32'h0, 0});
    tbl.push_back('{0, 1, 0, 32'h50, 2'b10, 32'h0, 1, 32'hFEEDFACE, 0});
    tbl.push_back('{0, 1, 0, 32'h410, 2'b10, 32'h0, 1, 32'hA5223344, 0});
    tbl.push_back('{1, 0, 1, 32'h8, 2'b10, 32'hAAAA5555, 0, 32'h0, 0});
    tbl.push_back('{1, 1, 0, 32'h8, 2'b10, 32'h0, 1, 32'hAAAA5555, 0});
    tbl.push_back('{1, 1, 0, 32'hB, 2'b00, 32'h0, 1, 32'h000000AA, 0});
    tbl.push_back('{1, 0, 1, 32'h300, 2'b10, 32'h00C0FFEE, 0, 32'h0, 0});
    tbl.push_back('{2, 0, 1, 32'h0, 2'b10, 32'h600DCAFE, 0, 32'h0, 0});
    tbl.push_back('{2, 1, 0, 32'h0, 2'b10, 32'h0, 1, 32'h600DCAFE, 0});
    tbl.push_back('{2, 0, 1, 32'h300, 2'b10, 32'h00C0FFEE, 0, 32'h0, 0});

    foreach (tbl[i]) begin
      access(tbl[i].k, tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].s, tbl[i].d,
             1'b0, v, q, e, ok);
      check($sformatf("vec%0d_seq", i), 64'(ok), 64'(1));
      check($sformatf("vec%0d_vld", i), 64'(v), 64'(tbl[i].ev));
      check($sformatf("vec%0d_err", i), 64'(e), 64'(tbl[i].ee));
      if (tbl[i].ev) check($sformatf("vec%0d_data", i), 64'(q), 64'(tbl[i].eq));
    end

    // Requests toggled while busy (and during DONE) must be ignored.
    for (int k = 1; k < 3; k++) begin
      access(k, 1'b0, 1'b1, 32'h4, 2'b10, 32'h11112222, 1'b1, v, q, e, ok);
      check($sformatf("noise%0d_seq", k), 64'(ok), 64'(1));
      access(k, 1'b1, 1'b0, 32'h300, 2'b10, 32'h0, 1'b0, v, q, e, ok);
      check($sformatf("noise%0d_seq2", k), 64'(ok), 64'(1));
      check($sformatf("noise%0d_data", k), 64'({v, q}), {31'b0, 1'b1, 32'h00C0FFEE});
      access(k, 1'b1, 1'b0, 32'h4, 2'b10, 32'h0, 1'b0, v, q, e, ok);
      check($sformatf("noise%0d_wr", k), 64'({v, q}), {31'b0, 1'b1, 32'h11112222});
    end

    held(0, 32'h10, 32'hA5223344);
    held(1, 32'h8, 32'hAAAA5555);
    held(2, 32'h0, 32'h600DCAFE);

    // Reset in the middle of a long write abandons it.
    drive(2, 1'b0, 1'b1, 32'h0, 2'b10, 32'h12345678);
    repeat (5) @(negedge clk);
    drive(2, 1'b0, 1'b0, 32'b0, 2'b00, 32'b0);
    check("midwait_busy", 64'(busy[2]), 64'(1));
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++)
      check($sformatf("midrst%0d", k),
            {29'b0, rd_data[k], rd_vld[k], busy[k], err[k]}, 64'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    access(2, 1'b1, 1'b0, 32'h0, 2'b10, 32'h0, 1'b0, v, q, e, ok);
    check("midrst_seq", 64'(ok), 64'(1));
    check("midrst_data", 64'({v, q}), {31'b0, 1'b1, 32'h600DCAFE});

    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 16; i++) begin
        a = 32'h100 + 32'(4 * i);
        d = $urandom;
        access(k, 1'b0, 1'b1, a, 2'b10, d, 1'b0, v, q, e, ok);
        m_write(k, a, 2'b10, d);
        check($sformatf("init%0d_%0d", k, i), 64'(ok), 64'(1));
      end
      for (int j = 0; j < 60; j++) begin
        a = 32'h100 + 32'($urandom_range(0, 63))
          + (32'($urandom_range(0, 3)) << 10);
        s = 2'($urandom);
        d = $urandom;
        w = 1'($urandom);
        r = !w || ($urandom_range(0, 3) == 0);
        access(k, r, w, a, s, d, 1'b0, v, q, e, ok);
        check($sformatf("rnd%0d_%0d_seq", k, j), 64'(ok), 64'(1));
        check($sformatf("rnd%0d_%0d_err", k, j), 64'(e), 64'(mis(a, s)));
        if (w) begin
          check($sformatf("rnd%0d_%0d_vld", k, j), 64'(v), 64'(0));
          m_write(k, a, s, d);
        end else begin
          check($sformatf("rnd%0d_%0d_rd", k, j), 64'({v, q}),
                {31'b0, 1'b1, m_read(k, a, s)});
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_ram_responder.md
# data_ram_responder

Memory-side responder for the core's simple AHB-style load/store port. It accepts one read or write at a time from the executor, and inserts a programmable number of wait states signalled on `ahb_busy`. It stores data in a word-organised RAM with byte/halfword/word lane handling, and returns read data with a single-cycle `ahb_rd_vld` strobe. It sits on the SoC data side opposite the core, and is the default data RAM behind the core's `ahb_*` bus.

## Interface
- `ADDR_WIDTH`, 12: word-address bits; depth is 2^ADDR_WIDTH 32-bit words; `ahb_addr[ADDR_WIDTH+1:2]` indexes the RAM, upper address bits are ignored.
- `WAIT_CYCLES`, 1: wait states per access, legal range 0..15.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `ahb_rd_en` in 1: read request, level, sampled only when `ahb_busy`=0.
- `ahb_wr_en` in 1: write request, level, sampled only when `ahb_busy`=0.
- `ahb_addr` in 32: byte address.
- `ahb_wr_data` in 32: write data, right-justified for byte/halfword.
- `ahb_size` in 2: 00 byte, 01 halfword, 10 word, 11 treated as word.
- `ahb_rd_data` out 32: read data, zero-extended and right-justified; valid only with `ahb_rd_vld`.
- `ahb_rd_vld` out 1: one-cycle read-completion strobe.
- `ahb_busy` out 1: responder cannot accept a request.
- `ahb_err` out 1: one-cycle misalignment fault strobe; tied 0 unless `MISALIGN_FAULT_EN` is defined.

## Operation
- FSM states:
  - IDLE: accepts requests.
  - WAIT: counts wait states.
  - DONE: completes the access.
- Acceptance: at a rising edge in IDLE with `ahb_rd_en|ahb_wr_en`=1.
  - Latch address, size, write data and type.
  - If both enables are high, the write wins and the read is dropped (no `ahb_rd_vld`).
- IDLE transitions on acceptance:
  - WAIT_CYCLES>0: go to WAIT and load a 4-bit counter with WAIT_CYCLES-1.
  - WAIT_CYCLES=0: go straight to DONE.
- WAIT: decrement the counter each cycle; go to DONE when the counter is 0.
- DONE: perform the access, then return to IDLE.
  - Write: update the RAM.
  - Read: register the data and pulse `ahb_rd_vld`.
- `ahb_busy` is a registered output: 1 in WAIT, 0 in IDLE and DONE.
  - The initiator holds its request while `ahb_busy`=1.
  - Enables seen while busy are ignored; nothing is queued.
- Write lanes:
  - Byte: `wr_data[7:0]` is written to lane `addr[1:0]`.
  - Halfword: `wr_data[15:0]` is written to lanes {`addr[1]`,0}..{`addr[1]`,1}.
  - Word: all 32 bits are written.
  - Other lanes are preserved.
- Read lanes:
  - Byte: `{24'b0, lane addr[1:0]}`.
  - Halfword: `{16'b0, half addr[1]}`.
  - Word: the full word.
- Misalignment is defined as halfword with `addr[0]`=1, or word with `addr[1:0]`≠0.
- RAM contents are not reset.

## Timing
- Reset values:
  - Outputs: `ahb_rd_data`=0, `ahb_rd_vld`=0, `ahb_busy`=0, `ahb_err`=0.
  - FSM returns to IDLE and the counter is cleared.
- Accept edge is T0. Busy is high in cycles T0+1..T0+WAIT_CYCLES.
- Completion occurs in cycle T0+WAIT_CYCLES+1:
  - `ahb_rd_vld` is high in that cycle.
  - A write is visible to a read accepted at or after that cycle's edge.
- Read latency is WAIT_CYCLES+1 cycles from accept to `ahb_rd_vld`. With WAIT_CYCLES=0, `ahb_busy` never asserts.
- A new request presented during the DONE cycle is not accepted. The earliest next accept is the first edge after DONE.
- Throughput is one access per WAIT_CYCLES+2 cycles.
- If reset asserts mid-access, the access is abandoned: a pending write is dropped and no `ahb_rd_vld` is produced.

## Configuration
- `MISALIGN_FAULT_EN` defined:
  - A misaligned access is accepted and timed normally, but the RAM is not written.
  - `ahb_err` pulses in the DONE cycle.
  - For reads, `ahb_rd_vld` also pulses with `ahb_rd_data`=0.
- `MISALIGN_FAULT_EN` undefined:
  - Low address bits beyond the size are ignored: halfword uses `addr[1]`, word ignores `addr[1:0]`.
  - `ahb_err` is constant 0.

## Test plan
- WAIT_CYCLES=1: write word 0xDEADBEEF @0x10, then read @0x10 -> busy high 1 cycle per access; `ahb_rd_vld` 2 cycles after read accept with `ahb_rd_data`=0xDEADBEEF.
- Byte write 0xA5 @0x13 over word 0x11223344 @0x10 -> word reads 0xA5223344; byte read @0x13 returns 0x000000A5.
- Halfword write 0xCAFE @0x22, then halfword read @0x22 -> 0x0000CAFE; lanes 0x20..0x21 unchanged.
- Simultaneous `ahb_rd_en`=`ahb_wr_en`=1 @0x30 with data 0x5 -> write performed, no `ahb_rd_vld`; a subsequent read returns 0x5. Requests toggled while busy are ignored.
- WAIT_CYCLES=0 and WAIT_CYCLES=15: back-to-back reads -> `ahb_rd_vld` at accept+1 and accept+16 respectively. Assert `rst_n` low mid-WAIT -> all outputs 0, pending write absent on re-read.
- With `MISALIGN_FAULT_EN`: word write @0x41 -> `ahb_err` pulse, RAM unchanged. Halfword read @0x41 -> `ahb_err`+`ahb_rd_vld`, data 0. Without the macro, the same word write lands at 0x40.
